// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory
// address and holds the IF/ID pipeline register (instruction, PC, valid).
// Handles stalls, redirect flushes and a sticky fault on misaligned redirects.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruc,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   output logic        fault
);

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      HALT
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instruc_q, instruc_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic        instr_valid_q, instr_valid_d;
   logic        fault_q, fault_d;

   logic        misaligned;

   assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);

   // State and pipeline registers; synchronous reset dominates everything
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= BOOT;
         pc_q          <= RESET_PC;
         instruc_q     <= NOP;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instruc_q     <= instruc_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         fault_q       <= fault_d;
      end
   end

   // Next-state: one boot cycle, then run until a misaligned redirect halts
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (misaligned) state_d = HALT;
         HALT:    state_d = HALT;
         default: state_d = BOOT;
      endcase
   end

   // Datapath next values; in RUN the priority is fault > redirect > stall > advance
   always_comb begin
      pc_d          = pc_q;
      instruc_d     = instruc_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      fault_d       = fault_q;
      unique case (state_q)
         BOOT: begin
            // hold everything; stall and redirect are ignored
         end
         RUN: begin
            if (misaligned) begin
               fault_d       = 1'b1;
               instruc_d     = NOP;
               instr_valid_d = 1'b0;
            end else if (redirect) begin
               // flush overrides a simultaneous stall
               pc_d          = redirect_pc;
               instruc_d     = NOP;
               instr_valid_d = 1'b0;
            end else if (!stall) begin
               instruc_d     = imem_rdata;
               instr_pc_d    = pc_q;
               instr_valid_d = 1'b1;
               pc_d          = pc_q + 32'd4;
            end
         end
         HALT: begin
            fault_d       = 1'b1;
            instr_valid_d = 1'b0;
         end
         default: begin
            instr_valid_d = 1'b0;
         end
      endcase
   end

   assign imem_addr   = pc_q;
   assign instruc     = instruc_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign fault       = fault_q;

endmodule
